// File: rtl/search_scheduler.sv
// search_scheduler: one-job-at-a-time sequencer for the parallel comparator
// bank. Sweeps every key-aligned window of the latched segment, NUM_CMP per
// cycle, and reports first match position and match count.
module search_scheduler #(
  parameter int DATA_W  = 1024,
  parameter int KEY_W   = 64,
  parameter int NUM_CMP = 4,
  parameter int POS_W   = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_data,
  input  logic [KEY_W-1:0]  req_key,
  input  logic              req_mode,
  input  logic              abort,
  output logic              busy,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_found,
  output logic [POS_W-1:0]  resp_pos,
  output logic [POS_W-1:0]  resp_count
);

  localparam int unsigned LASTP = DATA_W - KEY_W;
  localparam int unsigned NCMP  = NUM_CMP;
  localparam int unsigned NSTEP = (LASTP + NCMP) / NCMP;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] data_q;
  logic [KEY_W-1:0]  key_q;
  logic              mode_q;
  logic [POS_W-1:0]  step;
  logic [POS_W-1:0]  count;
  logic [POS_W-1:0]  pos;
  logic              found;

  logic [NCMP-1:0]   hits;
  logic              any_hit;
  logic              last_step;
  logic              scan_done;
  logic [POS_W-1:0]  low_pos;
  logic [POS_W-1:0]  scan_count;
  logic [POS_W-1:0]  scan_pos;
  logic              scan_found;
  int unsigned       base;
  int unsigned       wpos;
  int unsigned       low;
  int unsigned       pc;

  assign req_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign resp_valid = (state == DONE);

  // Comparator bank: one window per lane, lanes past the last window masked.
  always_comb begin
    hits = '0;
    wpos = 0;
    base = 32'(step) * NCMP;
    for (int unsigned i = 0; i < NCMP; i++) begin
      wpos = base + i;
      if (wpos <= LASTP)
        hits[i] = (data_q[DATA_W-1-wpos -: KEY_W] == key_q);
    end
  end

  // Lowest hit lane, hit popcount and per-step result update.
  always_comb begin
    low = 0;
    pc  = 0;
    for (int unsigned i = NCMP; i > 0; i--) begin
      if (hits[i-1]) low = i - 1;
    end
    for (int unsigned i = 0; i < NCMP; i++) begin
      pc = pc + 32'(hits[i]);
    end
    any_hit   = |hits;
    low_pos   = POS_W'(base + low);
    last_step = (step == POS_W'(NSTEP - 1));
    if (mode_q) begin
      scan_count = count + POS_W'(pc);
      scan_found = found | any_hit;
      scan_pos   = (!found && any_hit) ? low_pos : pos;
      scan_done  = last_step;
    end else begin
      scan_count = any_hit ? POS_W'(1) : '0;
      scan_found = any_hit;
      scan_pos   = any_hit ? low_pos : '0;
      scan_done  = any_hit | last_step;
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; abort in SCAN takes priority over completion.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_valid) state_nxt = SCAN;
      SCAN: begin
        if (abort)          state_nxt = IDLE;
        else if (scan_done) state_nxt = DONE;
      end
      DONE: if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Job latch, scan progress and response registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q     <= '0;
      key_q      <= '0;
      mode_q     <= 1'b0;
      step       <= '0;
      count      <= '0;
      pos        <= '0;
      found      <= 1'b0;
      resp_found <= 1'b0;
      resp_pos   <= '0;
      resp_count <= '0;
    end else if (state == IDLE) begin
      if (req_valid) begin
        data_q <= req_data;
        key_q  <= req_key;
        mode_q <= req_mode;
        step   <= '0;
        count  <= '0;
        pos    <= '0;
        found  <= 1'b0;
      end
    end else if (state == SCAN && !abort) begin
      step  <= step + 1'b1;
      count <= scan_count;
      pos   <= scan_pos;
      found <= scan_found;
      if (scan_done) begin
        resp_found <= scan_found;
        resp_pos   <= scan_pos;
        resp_count <= scan_count;
      end
    end
  end

endmodule

// File: tb/tb_search_scheduler.sv
// Testbench for search_scheduler: directed vector table, hand-written
// multi-cycle sequences, and random jobs against a window-scan model.
module tb_search_scheduler;

  localparam int DATA_W  = 1024;
  localparam int KEY_W   = 64;
  localparam int NUM_CMP = 4;
  localparam int POS_W   = 10;
  localparam int LASTP   = DATA_W - KEY_W;
  localparam int NSTEP   = (LASTP + NUM_CMP) / NUM_CMP;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [DATA_W-1:0] req_data = '0;
  logic [KEY_W-1:0]  req_key = '0;
  logic              req_mode = 1'b0;
  logic              abort = 1'b0;
  logic              busy;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic              resp_found;
  logic [POS_W-1:0]  resp_pos;
  logic [POS_W-1:0]  resp_count;

  int errors = 0;
  int checks = 0;

  search_scheduler #(
    .DATA_W(DATA_W), .KEY_W(KEY_W), .NUM_CMP(NUM_CMP), .POS_W(POS_W)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_key(req_key), .req_mode(req_mode),
    .abort(abort), .busy(busy),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_found(resp_found), .resp_pos(resp_pos), .resp_count(resp_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic [KEY_W-1:0]  k;
    logic              m;
    int                f;
    int                p;
    int                c;
    int                lat;
  } vec_t;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Sets `len` consecutive positions starting at `start` to one.
  function automatic logic [DATA_W-1:0] with_run(input logic [DATA_W-1:0] d,
                                                  input int start, input int len);
    logic [DATA_W-1:0] r = d;
    for (int j = 0; j < len; j++) r[DATA_W-1-(start+j)] = 1'b1;
    return r;
  endfunction

  // Writes the key so that window `start` equals it.
  function automatic logic [DATA_W-1:0] with_key(input logic [DATA_W-1:0] d,
                                                  input int start, input logic [KEY_W-1:0] k);
    logic [DATA_W-1:0] r = d;
    for (int j = 0; j < KEY_W; j++) r[DATA_W-1-(start+j)] = k[KEY_W-1-j];
    return r;
  endfunction

  // Reference: scan all windows left to right by shifting the segment.
  task automatic ref_job(input logic [DATA_W-1:0] d, input logic [KEY_W-1:0] k,
                         input logic m, output int f, output int p, output int c,
                         output int lat);
    logic [DATA_W-1:0] sh;
    f = 0; p = 0; c = 0; lat = NSTEP;
    for (int q = 0; q <= LASTP; q++) begin
      sh = d << q;
      if (sh[DATA_W-1 -: KEY_W] == k) begin
        if (f == 0) begin f = 1; p = q; end
        c++;
        if (!m) begin lat = q / NUM_CMP + 1; break; end
      end
    end
  endtask

  task automatic start_job(input string name, input logic [DATA_W-1:0] d,
                           input logic [KEY_W-1:0] k, input logic m);
    check({name, ".req_ready"}, int'(req_ready), 1);
    req_data = d; req_key = k; req_mode = m; req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    req_data = {32{$urandom}};
    req_key = {$urandom, $urandom};
    req_mode = ~m;
    check({name, ".busy"}, int'(busy), 1);
  endtask

  task automatic wait_resp(input string name, output int lat);
    lat = 0;
    while (!resp_valid && lat < 400) begin
      @(posedge clock); #1;
      lat++;
    end
    if (!resp_valid) check({name, ".timeout"}, 0, 1);
  endtask

  task automatic take_resp;
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
  endtask

  task automatic run_job(input string name, input logic [DATA_W-1:0] d,
                         input logic [KEY_W-1:0] k, input logic m,
                         input int f, input int p, input int c, input int el);
    int lat;
    start_job(name, d, k, m);
    wait_resp(name, lat);
    check({name, ".lat"}, lat, el);
    check({name, ".found"}, int'(resp_found), f);
    check({name, ".pos"}, int'(resp_pos), p);
    check({name, ".count"}, int'(resp_count), c);
    take_resp();
  endtask

  vec_t tbl[12];
  logic [DATA_W-1:0] ones_k0, ones_k960, pair, pat300, zeros, rd;
  logic [KEY_W-1:0]  ones, pkey, rk;
  int f, p, c, lat;

  initial begin
    zeros = '0;
    ones = '1;
    pkey = 64'hA5C3_0F1E_7B29_D487;
    ones_k0   = with_run(zeros, 0, 64);
    ones_k960 = with_run(zeros, 960, 64);
    pair      = with_run(with_run(zeros, 6, 65), 500, 64);
    pat300    = with_key(zeros, 300, pkey);

    tbl[0]  = '{ones_k0,   ones, 1'b0, 1, 0,   1,   1};
    tbl[1]  = '{ones_k0,   ones, 1'b1, 1, 0,   1,   241};
    tbl[2]  = '{ones_k960, ones, 1'b0, 1, 960, 1,   241};
    tbl[3]  = '{ones_k960, ones, 1'b1, 1, 960, 1,   241};
    tbl[4]  = '{zeros,     '0,   1'b1, 1, 0,   961, 241};
    tbl[5]  = '{zeros,     '0,   1'b0, 1, 0,   1,   1};
    tbl[6]  = '{pair,      ones, 1'b1, 1, 6,   3,   241};
    tbl[7]  = '{pair,      ones, 1'b0, 1, 6,   1,   2};
    tbl[8]  = '{zeros,     ones, 1'b0, 0, 0,   0,   241};
    tbl[9]  = '{zeros,     ones, 1'b1, 0, 0,   0,   241};
    tbl[10] = '{pat300,    pkey, 1'b0, 1, 300, 1,   76};
    tbl[11] = '{pat300,    pkey, 1'b1, 1, 300, 1,   241};

    // Reset values.
    repeat (3) @(posedge clock);
    #1;
    check("rst.req_ready", int'(req_ready), 1);
    check("rst.busy", int'(busy), 0);
    check("rst.resp_valid", int'(resp_valid), 0);
    check("rst.resp_found", int'(resp_found), 0);
    check("rst.resp_pos", int'(resp_pos), 0);
    check("rst.resp_count", int'(resp_count), 0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Directed table.
    foreach (tbl[i])
      run_job($sformatf("vec%0d", i), tbl[i].d, tbl[i].k, tbl[i].m,
              tbl[i].f, tbl[i].p, tbl[i].c, tbl[i].lat);

    // No match with response held back, then back-to-back accept.
    start_job("hold", zeros, ones, 1'b0);
    wait_resp("hold", lat);
    check("hold.lat", lat, 241);
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      check("hold.resp_valid", int'(resp_valid), 1);
      check("hold.req_ready", int'(req_ready), 0);
      check("hold.found", int'(resp_found), 0);
      check("hold.pos", int'(resp_pos), 0);
      check("hold.count", int'(resp_count), 0);
    end
    // abort is ignored while a response is pending.
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    check("done_abort.resp_valid", int'(resp_valid), 1);
    take_resp();
    run_job("b2b", pat300, pkey, 1'b0, 1, 300, 1, 76);

    // Abort at step 50 keeps the previous response fields.
    start_job("abort50", zeros, ones, 1'b1);
    repeat (50) begin @(posedge clock); #1; end
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    check("abort50.req_ready", int'(req_ready), 1);
    check("abort50.busy", int'(busy), 0);
    check("abort50.found", int'(resp_found), 1);
    check("abort50.pos", int'(resp_pos), 300);
    check("abort50.count", int'(resp_count), 1);
    repeat (5) begin
      @(posedge clock); #1;
      check("abort50.resp_valid", int'(resp_valid), 0);
    end

    // Abort on the final step beats completion.
    start_job("abort_last", zeros, '0, 1'b1);
    repeat (NSTEP - 1) begin @(posedge clock); #1; end
    check("abort_last.busy", int'(busy), 1);
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    check("abort_last.resp_valid", int'(resp_valid), 0);
    check("abort_last.req_ready", int'(req_ready), 1);
    check("abort_last.count", int'(resp_count), 1);

    // Reset at step 100 drops everything, then a normal job.
    start_job("rst100", zeros, ones, 1'b0);
    repeat (100) begin @(posedge clock); #1; end
    reset = 1'b1;
    #1;
    check("rst100.req_ready", int'(req_ready), 1);
    check("rst100.busy", int'(busy), 0);
    check("rst100.resp_valid", int'(resp_valid), 0);
    check("rst100.found", int'(resp_found), 0);
    check("rst100.pos", int'(resp_pos), 0);
    check("rst100.count", int'(resp_count), 0);
    @(posedge clock); #1;
    reset = 1'b0;
    run_job("post_rst", pair, ones, 1'b1, 1, 6, 3, 241);

    // Random jobs against the reference model.
    for (int n = 0; n < 16; n++) begin
      for (int j = 0; j < DATA_W / 32; j++)
        rd[32*j +: 32] = $urandom & $urandom & $urandom;
      case ($urandom_range(0, 3))
        0: rk = '0;
        1: rk = {$urandom, $urandom};
        default: begin
          rd = with_key(rd, int'($urandom_range(0, LASTP)), {$urandom, $urandom});
          rk = '0;
          // Pick a key actually present somewhere in the segment.
          begin
            logic [DATA_W-1:0] sh;
            sh = rd << $urandom_range(0, LASTP);
            rk = sh[DATA_W-1 -: KEY_W];
          end
        end
      endcase
      ref_job(rd, rk, 1'($urandom_range(0, 1)) == 1'b1 ? 1'b1 : 1'b0, f, p, c, lat);
      begin
        logic m;
        m = 1'($urandom_range(0, 1));
        ref_job(rd, rk, m, f, p, c, lat);
        run_job($sformatf("rnd%0d", n), rd, rk, m, f, p, c, lat);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
